// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types for the instruction fetch unit: address and
//                instruction words, the delivered fetch packet and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef N
`define N 2
`endif

package fetch_pkg;

  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_packet_t;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Circular FIFO of fetch packets accepting up to WIDTH entries
//                and delivering up to WIDTH oldest entries per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int WIDTH = `N,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int PW    = $clog2(DEPTH),
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [CW-1:0]             enq_cnt_i,
  input  fetch_packet_t [WIDTH-1:0] enq_data_i,
  input  logic [CW-1:0]             spots_i,
  output fetch_packet_t [WIDTH-1:0] deq_data_o,
  output logic [CW-1:0]             deq_cnt_o,
  output logic [NW-1:0]             count_o
);

  fetch_packet_t mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [NW-1:0] count_q;

  // Delivery width is the smallest of occupancy, downstream room and WIDTH;
  // a flush cycle delivers nothing.
  always_comb begin : deq_calc
    int n;
    n = int'(spots_i);
    if (n > WIDTH) n = WIDTH;
    if (n > int'(count_q)) n = int'(count_q);
    if (flush_i) n = 0;
    deq_cnt_o = CW'(n);
    for (int i = 0; i < WIDTH; i++) begin
      deq_data_o[i] = (i < n) ? mem_q[rd_ptr_q + PW'(i)] : '0;
    end
  end

  // Storage writes; pointer arithmetic wraps naturally since DEPTH is 2^PW.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(enq_cnt_i)) mem_q[wr_ptr_q + PW'(i)] <= enq_data_i[i];
    end
  end

  // Pointer and occupancy update by the net change of enqueue and dequeue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(deq_cnt_o);
      wr_ptr_q <= wr_ptr_q + PW'(enq_cnt_i);
      count_q  <= NW'(int'(count_q) + int'(enq_cnt_i) - int'(deq_cnt_o));
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch: issues one memory request at a time,
//                trims responses at the first predicted-taken slot, follows
//                predictions and mispredict redirects, and buffers packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int    FETCH_WIDTH = `N,
  parameter  int    BUF_DEPTH   = 8,
  parameter  addr_t RESET_PC    = '0,
  localparam int    CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  output logic                            imem_req_o,
  output addr_t                           imem_addr_o,
  input  logic                            imem_gnt_i,
  input  logic                            imem_rvalid_i,
  input  inst_t         [FETCH_WIDTH-1:0] imem_rdata_i,
  input  logic          [FETCH_WIDTH-1:0] pred_taken_i,
  input  addr_t                           pred_target_i,
  input  logic                            mispredict_i,
  input  addr_t                           recovery_pc_i,
  input  logic          [CNT_W-1:0]       inst_buffer_spots_i,
  output fetch_packet_t [FETCH_WIDTH-1:0] inst_buffer_inputs_o,
  output logic          [CNT_W-1:0]       instructions_valid_o
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e                    state_q, state_d;
  addr_t                           pc_q, pc_d;
  logic          [CNT_W-1:0]       keep_cnt;
  logic                            taken_any;
  logic          [CNT_W-1:0]       enq_cnt;
  fetch_packet_t [FETCH_WIDTH-1:0] enq_data;
  logic          [OCC_W-1:0]       occ;

  // Slots up to and including the lowest predicted-taken one survive.
  always_comb begin : keep_calc
    int n;
    n         = FETCH_WIDTH;
    taken_any = 1'b0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (pred_taken_i[i]) begin
        n         = i + 1;
        taken_any = 1'b1;
      end
    end
    keep_cnt = CNT_W'(n);
  end

  // Each packet carries its instruction and the PC of its slot.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      enq_data[i].inst = imem_rdata_i[i];
      enq_data[i].pc   = pc_q + addr_t'(INST_BYTES * i);
    end
  end

  // Only issue when a full-width response is guaranteed to fit.
  assign imem_req_o  = (state_q == S_REQ) && (int'(occ) <= BUF_DEPTH - FETCH_WIDTH)
                       && !mispredict_i && !reset_i;
  assign imem_addr_o = pc_q;

  // Next state, next PC and enqueue count; mispredict overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    enq_cnt = '0;
    if (mispredict_i) begin
      pc_d = recovery_pc_i;
      if (state_q == S_WAIT) state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_o && imem_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            enq_cnt = keep_cnt;
            pc_d    = taken_any ? pred_target_i
                                : pc_q + addr_t'(INST_BYTES * FETCH_WIDTH);
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .WIDTH (FETCH_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .flush_i    (mispredict_i),
    .enq_cnt_i  (enq_cnt),
    .enq_data_i (enq_data),
    .spots_i    (inst_buffer_spots_i),
    .deq_data_o (inst_buffer_inputs_o),
    .deq_cnt_o  (instructions_valid_o),
    .count_o    (occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Randomized bench for fetch_unit with a memory responder, a
//                queue-based reference model and a scoreboard monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                imem_req;
  addr_t               imem_addr;
  logic                gnt = 1'b0;
  logic                rvalid = 1'b0;
  inst_t         [1:0] rdata = '0;
  logic          [1:0] taken = '0;
  addr_t               target = '0;
  logic                mispredict = 1'b0;
  addr_t               recovery = '0;
  logic          [1:0] spots = '0;
  fetch_packet_t [1:0] outp;
  logic          [1:0] ivalid;

  fetch_unit #(.FETCH_WIDTH(2), .BUF_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock_i              (clk),
    .reset_i              (rst),
    .imem_req_o           (imem_req),
    .imem_addr_o          (imem_addr),
    .imem_gnt_i           (gnt),
    .imem_rvalid_i        (rvalid),
    .imem_rdata_i         (rdata),
    .pred_taken_i         (taken),
    .pred_target_i        (target),
    .mispredict_i         (mispredict),
    .recovery_pc_i        (recovery),
    .inst_buffer_spots_i  (spots),
    .inst_buffer_inputs_o (outp),
    .instructions_valid_o (ivalid)
  );

  always #5 clk = ~clk;

  // Reference model: expected packets in delivery order plus fetch PC.
  fetch_packet_t q[$];
  addr_t m_pc      = 32'h0;
  bit    m_wait    = 1'b0;  // a live request is outstanding
  bit    m_drain   = 1'b0;  // a squashed request's response is still owed
  bit    mem_owe   = 1'b0;  // memory still has to answer some request
  int    mem_lat   = 0;
  addr_t mem_addr  = '0;
  bit    exp_req_now = 1'b0;
  int    checks    = 0;
  int    failures  = 0;
  int    delivered = 0;

  function automatic inst_t inst_of(input addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle's outputs and retires delivered packets.
  always @(negedge clk) begin : monitor
    int ev;
    int sp;
    exp_req_now = !rst && !mispredict && !m_wait && !m_drain && (q.size() <= 6);
    chk("imem_req", 64'(imem_req), 64'(exp_req_now));
    if (exp_req_now && imem_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    sp = int'(spots);
    ev = q.size();
    if (sp < ev) ev = sp;
    if (ev > 2) ev = 2;
    if (rst || mispredict) ev = 0;
    chk("instructions_valid", 64'(ivalid), 64'(ev));
    for (int i = 0; i < 2; i++) begin
      if (i < ev) begin
        chk("pkt_pc", 64'(outp[i].pc), 64'(q[i].pc));
        chk("pkt_inst", 64'(outp[i].inst), 64'(q[i].inst));
      end else begin
        chk("slot_zero", 64'(outp[i]), 64'h0);
      end
    end
    for (int i = 0; i < ev; i++) begin
      void'(q.pop_front());
      delivered++;
    end
  end

  // One cycle of stimulus, then model update once outputs were sampled.
  task automatic step(input int gnt_pct, input int lat_max, input int sp_mode,
                      input int mp_pct, input int taken_pct, input bit do_rst);
    bit resp_now;
    @(posedge clk);
    #1;
    resp_now   = 1'b0;
    rst        = do_rst;
    mispredict = !m_drain && (($urandom % 100) < mp_pct);
    recovery   = addr_t'($urandom_range(0, 4095)) << 2;
    rvalid     = 1'b0;
    taken      = (($urandom % 100) < taken_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
    target     = addr_t'($urandom_range(0, 4095)) << 2;
    rdata[0]   = $urandom;
    rdata[1]   = $urandom;
    if (mem_owe) begin
      if (mem_lat == 0) begin
        rvalid   = 1'b1;
        resp_now = 1'b1;
        rdata[0] = inst_of(mem_addr);
        rdata[1] = inst_of(mem_addr + 32'd4);
      end else begin
        mem_lat--;
      end
    end else if (($urandom % 100) < 5) begin
      rvalid = 1'b1;  // stray response while idle must be ignored
    end
    gnt   = !mem_owe && (($urandom % 100) < gnt_pct);
    spots = (sp_mode < 0) ? 2'($urandom_range(0, 2)) : 2'(sp_mode);
    #6;
    if (resp_now) mem_owe = 1'b0;
    if (rst) begin
      q.delete();
      m_pc    = 32'h0;
      m_wait  = 1'b0;
      m_drain = 1'b0;
    end else if (mispredict) begin
      q.delete();
      m_pc = recovery;
      if (m_wait) begin
        m_wait  = 1'b0;
        m_drain = !rvalid;
      end
    end else if (m_wait && rvalid) begin
      int k;
      k = taken[0] ? 0 : 1;
      for (int i = 0; i <= k; i++) begin
        fetch_packet_t p;
        p.pc   = m_pc + addr_t'(4 * i);
        p.inst = inst_of(p.pc);
        q.push_back(p);
      end
      m_pc   = (taken != 2'b00) ? target : m_pc + 32'd8;
      m_wait = 1'b0;
    end else if (m_drain && rvalid) begin
      m_drain = 1'b0;
    end else if (exp_req_now && gnt) begin
      m_wait   = 1'b1;
      mem_owe  = 1'b1;
      mem_addr = m_pc;
      mem_lat  = $urandom_range(0, lat_max);
    end
  endtask

  initial begin
    repeat (3) step(0, 0, 2, 0, 0, 1);
    // Straight-line fetch, one-cycle memory, full downstream room.
    repeat (20) step(100, 0, 2, 0, 0, 0);
    // Predicted-taken trimming and redirects.
    repeat (60) step(100, 0, 2, 0, 50, 0);
    // Back-pressure: fill to capacity, then drain one per cycle.
    repeat (30) step(100, 0, 0, 0, 0, 0);
    repeat (30) step(100, 0, 1, 0, 0, 0);
    // Mispredicts with variable memory latency.
    repeat (400) step(80, 3, -1, 6, 30, 0);
    // Reset in the middle of an outstanding request.
    for (int r = 0; r < 4; r++) begin
      for (int g = 0; g < 50 && !m_wait; g++) step(100, 3, 2, 0, 0, 0);
      step(100, 3, 2, 0, 0, 1);
      step(100, 3, 2, 0, 0, 1);
      repeat (10) step(100, 3, -1, 0, 20, 0);
    end
    // Long randomized run.
    repeat (2500) step(70, 3, -1, 3, 30, 0);
    chk("delivered_progress", 64'(delivered > 300), 64'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
